mw_cook_controller: RTL and testbench

//  Control FSM for the microwave countdown datapath. Captures keypad digits into
//  a 3-digit BCD entry register (M:S S) and sequences the external countdown timer.

---
 rtl/mw_pkg.sv | 39 +++
 rtl/mw_cook_controller_if.sv | 38 +++
 rtl/mw_tick_gen.sv | 40 ++++
 rtl/mw_cook_controller.sv | 156 +++++++++++++++
 tb/tb_mw_cook_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mw_pkg.sv
// Shared definitions for the microwave cook controller.
//   - FSM state encoding (IDLE/COOK/PAUSE), as reported on state_o
//   - field widths for the BCD entry register and the keypad
//   - default prescaler divide for a 100 Hz system clock
//   - keypad one-hot helpers
package mw_pkg;

  localparam int unsigned BCD_W            = 4;
  localparam int unsigned ENTRY_W          = 12;
  localparam int unsigned KBD_W            = 10;
  localparam int unsigned TICK_DIV_DEFAULT = 100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2
  } mw_state_e;

  // True when exactly one keypad bit is set.
  function automatic logic is_onehot(input logic [KBD_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KBD_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n == 1;
  endfunction

  // Index of the set bit; only meaningful when is_onehot(v).
  function automatic logic [BCD_W-1:0] onehot_to_digit(input logic [KBD_W-1:0] v);
    logic [BCD_W-1:0] d;
    d = '0;
    for (int i = 0; i < KBD_W; i++) begin
      if (v[i]) d = BCD_W'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/mw_cook_controller_if.sv
// Front-panel and timer-side signal bundle of the cook controller.
//   master : front panel / timer environment (drives panel inputs, timer_zero)
//   slave  : mw_cook_controller
//   kbd[9:0]        one-hot keypad, active-high
//   startn/stopn/clearn  active-low buttons
//   door_closed     1 = door closed
//   timer_zero      countdown datapath reads 0:00
//   entry_bcd[11:0] {min, sec_tens, sec_ones} load value for the timer
//   load_timer/clear_timer/count_en  1-cycle timer strobes
//   mag_on          magnetron enable
//   state_o[1:0]    FSM state (debug)
interface mw_cook_controller_if;
  import mw_pkg::*;

  logic [KBD_W-1:0]   kbd;
  logic               startn;
  logic               stopn;
  logic               clearn;
  logic               door_closed;
  logic               timer_zero;
  logic [ENTRY_W-1:0] entry_bcd;
  logic               load_timer;
  logic               clear_timer;
  logic               count_en;
  logic               mag_on;
  logic [1:0]         state_o;

  modport master (
    output kbd, startn, stopn, clearn, door_closed, timer_zero,
    input  entry_bcd, load_timer, clear_timer, count_en, mag_on, state_o
  );

  modport slave (
    input  kbd, startn, stopn, clearn, door_closed, timer_zero,
    output entry_bcd, load_timer, clear_timer, count_en, mag_on, state_o
  );

endinterface

// File: rtl/mw_tick_gen.sv
// One-second tick prescaler.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : count this cycle (controller is cooking)
//   hold      : freeze the count this cycle (controller is leaving COOK)
//   restart   : force the count back to 0
//   tick      : 1-cycle pulse on the cycle the count wraps TICK_DIV-1 -> 0
module mw_tick_gen #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          wrap;
  logic          advance;

  always_comb begin
    wrap    = (cnt_q == CW'(TICK_DIV - 1));
    advance = en & ~hold & ~restart;
    tick    = advance & wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (advance) begin
      cnt_q <= wrap ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/mw_cook_controller.sv
// Microwave cook controller: registers the front-panel inputs, detects presses,
// shifts keypad digits into a 3-digit BCD entry, and sequences the external
// countdown timer (load/clear/count strobes) and the magnetron enable.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mw_cook_controller_if.slave (panel inputs, timer_zero, timer strobes,
//              entry_bcd, mag_on, state_o)
module mw_cook_controller
  import mw_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  mw_cook_controller_if.slave bus
);

  // Input sample (_s) and previous sample (_p) registers, reset to idle levels.
  logic [KBD_W-1:0] kbd_s, kbd_p;
  logic             startn_s, startn_p;
  logic             stopn_s, stopn_p;
  logic             clearn_s, clearn_p;
  logic             door_s;

  mw_state_e          state_q;
  logic [ENTRY_W-1:0] entry_q;
  logic               load_q, clear_q, count_q, mag_q;

  logic             key_press;
  logic [BCD_W-1:0] key_digit;
  logic             start_press, stop_press, clear_press;
  logic             halt;
  logic             zero_exit;
  logic             cook_leave;
  logic             presc_en, presc_restart;
  logic             tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbd_s    <= '0;
      kbd_p    <= '0;
      startn_s <= 1'b1;
      startn_p <= 1'b1;
      stopn_s  <= 1'b1;
      stopn_p  <= 1'b1;
      clearn_s <= 1'b1;
      clearn_p <= 1'b1;
      door_s   <= 1'b0;
    end else begin
      kbd_s    <= bus.kbd;
      kbd_p    <= kbd_s;
      startn_s <= bus.startn;
      startn_p <= startn_s;
      stopn_s  <= bus.stopn;
      stopn_p  <= stopn_s;
      clearn_s <= bus.clearn;
      clearn_p <= clearn_s;
      door_s   <= bus.door_closed;
    end
  end

  always_comb begin
    // A key counts only if the pad is one-hot now and that bit was not set before.
    key_press   = is_onehot(kbd_s) && ((kbd_s & ~kbd_p) != '0);
    key_digit   = onehot_to_digit(kbd_s);
    start_press = startn_p & ~startn_s;
    stop_press  = stopn_p & ~stopn_s;
    clear_press = clearn_p & ~clearn_s;
    halt        = stop_press | ~door_s;
    // timer_zero is stale on the first COOK cycle, before the load takes effect.
    zero_exit   = bus.timer_zero & ~load_q;
    cook_leave  = (state_q == COOK) & (clear_press | halt | zero_exit);
    presc_en      = (state_q == COOK);
    presc_restart = (state_q == IDLE);
  end

  mw_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (presc_en),
    .hold   (cook_leave),
    .restart(presc_restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      entry_q <= '0;
      load_q  <= 1'b0;
      clear_q <= 1'b0;
      count_q <= 1'b0;
      mag_q   <= 1'b0;
    end else begin
      load_q  <= 1'b0;
      clear_q <= 1'b0;
      count_q <= 1'b0;
      mag_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clear_press) begin
            entry_q <= '0;
            clear_q <= 1'b1;
          end else if (halt) begin
            // stop or open door outranks start and digit entry
          end else if (start_press) begin
            if (entry_q != '0) begin
              load_q  <= 1'b1;
              mag_q   <= 1'b1;
              state_q <= COOK;
            end
          end else if (key_press) begin
            entry_q <= {entry_q[ENTRY_W-BCD_W-1:0], key_digit};
          end
        end
        COOK: begin
          if (clear_press) begin
            entry_q <= '0;
            clear_q <= 1'b1;
            state_q <= IDLE;
          end else if (halt) begin
            state_q <= PAUSE;
          end else if (zero_exit) begin
            entry_q <= '0;
            state_q <= IDLE;
          end else begin
            count_q <= tick;
            mag_q   <= 1'b1;
          end
        end
        PAUSE: begin
          if (clear_press) begin
            entry_q <= '0;
            clear_q <= 1'b1;
            state_q <= IDLE;
          end else if (!halt && start_press) begin
            mag_q   <= 1'b1;
            state_q <= COOK;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.entry_bcd   = entry_q;
  assign bus.load_timer  = load_q;
  assign bus.clear_timer = clear_q;
  assign bus.count_en    = count_q;
  assign bus.mag_on      = mag_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_mw_cook_controller.sv
// Self-checking bench for mw_cook_controller. A behavioural countdown timer
// closes the loop on timer_zero; a reference model predicts every output each
// cycle from press events, a digit list and elapsed cook time.
module tb_mw_cook_controller;
  import mw_pkg::*;

  localparam int unsigned TICK_DIV = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mw_cook_controller_if bus ();

  mw_cook_controller #(
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_load, n_clear, n_count;
  logic door_lvl;

  // Behavioural timer, in whole seconds.
  int         secs;
  logic       pend_load, pend_clear, pend_count;
  logic [11:0] pend_entry;

  // Reference model state. Input history: [0] newest drive, [1]/[2] the two
  // samples the controller compares on the coming edge.
  logic [9:0] h_kbd [3];
  logic       h_start [3];
  logic       h_stop [3];
  logic       h_clear [3];
  logic       h_door [3];
  int         m_state;
  int         m_dig [3];
  int         m_elapsed;
  logic [1:0]  exp_state;
  logic [11:0] exp_entry;
  logic        exp_load, exp_clear, exp_count, exp_mag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_digits();
    m_dig[0] = 0;
    m_dig[1] = 0;
    m_dig[2] = 0;
  endtask

  task automatic model_step(input logic tz);
    logic [9:0] knew;
    logic key_ok, start_p, stop_p, clear_p, halt, prev_load;
    int dig;
    knew    = h_kbd[1] & ~h_kbd[2];
    key_ok  = ($countones(h_kbd[1]) == 1) && (knew != '0);
    dig = 0;
    for (int i = 0; i < 10; i++) if (h_kbd[1][i]) dig = i;
    start_p = h_start[2] && !h_start[1];
    stop_p  = h_stop[2] && !h_stop[1];
    clear_p = h_clear[2] && !h_clear[1];
    halt    = stop_p || !h_door[1];
    prev_load = exp_load;
    exp_load  = 1'b0;
    exp_clear = 1'b0;
    exp_count = 1'b0;
    case (m_state)
      0: begin
        if (clear_p) begin
          clear_digits();
          exp_clear = 1'b1;
        end else if (!halt && start_p) begin
          if (m_dig[0] + m_dig[1] + m_dig[2] != 0) begin
            exp_load  = 1'b1;
            m_state   = 1;
            m_elapsed = 0;
          end
        end else if (!halt && key_ok) begin
          m_dig[2] = m_dig[1];
          m_dig[1] = m_dig[0];
          m_dig[0] = dig;
        end
      end
      1: begin
        if (clear_p) begin
          clear_digits();
          exp_clear = 1'b1;
          m_state   = 0;
        end else if (halt) begin
          m_state = 2;
        end else if (tz && !prev_load) begin
          clear_digits();
          m_state = 0;
        end else begin
          m_elapsed++;
          exp_count = (m_elapsed % TICK_DIV == 0);
        end
      end
      default: begin
        if (clear_p) begin
          clear_digits();
          exp_clear = 1'b1;
          m_state   = 0;
        end else if (!halt && start_p) begin
          m_state = 1;
        end
      end
    endcase
    exp_state = 2'(m_state);
    exp_mag   = (m_state == 1);
    exp_entry = {4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
  endtask

  // One clock: compare, advance the timer, drive inputs, step the model.
  task automatic tick(input logic [9:0] k, input logic s, input logic p, input logic c,
                      input logic d);
    @(negedge clk);
    check("state", bus.state_o, exp_state);
    check("entry", bus.entry_bcd, exp_entry);
    check("load_timer", bus.load_timer, exp_load);
    check("clear_timer", bus.clear_timer, exp_clear);
    check("count_en", bus.count_en, exp_count);
    check("mag_on", bus.mag_on, exp_mag);
    if (bus.load_timer) n_load++;
    if (bus.clear_timer) n_clear++;
    if (bus.count_en) n_count++;
    // Strobes from the previous cycle take effect now, as on the real timer edge.
    if (pend_clear) secs = 0;
    else if (pend_load) secs = int'(pend_entry[11:8]) * 60 + int'(pend_entry[7:4]) * 10
                               + int'(pend_entry[3:0]);
    else if (pend_count && secs > 0) secs--;
    pend_clear = bus.clear_timer;
    pend_load  = bus.load_timer;
    pend_count = bus.count_en;
    pend_entry = bus.entry_bcd;
    bus.kbd = k;
    bus.startn = s;
    bus.stopn = p;
    bus.clearn = c;
    bus.door_closed = d;
    bus.timer_zero = (secs == 0);
    for (int i = 2; i > 0; i--) begin
      h_kbd[i] = h_kbd[i-1];
      h_start[i] = h_start[i-1];
      h_stop[i] = h_stop[i-1];
      h_clear[i] = h_clear[i-1];
      h_door[i] = h_door[i-1];
    end
    h_kbd[0] = k;
    h_start[0] = s;
    h_stop[0] = p;
    h_clear[0] = c;
    h_door[0] = d;
    model_step(bus.timer_zero);
  endtask

  task automatic idle(input int n);
    repeat (n) tick('0, 1'b1, 1'b1, 1'b1, door_lvl);
  endtask

  task automatic key(input int d);
    logic [9:0] k;
    k = '0;
    k[d] = 1'b1;
    repeat (2) tick(k, 1'b1, 1'b1, 1'b1, door_lvl);
    idle(2);
  endtask

  task automatic press_start();
    repeat (2) tick('0, 1'b0, 1'b1, 1'b1, door_lvl);
    idle(2);
  endtask

  task automatic press_stop();
    repeat (2) tick('0, 1'b1, 1'b0, 1'b1, door_lvl);
    idle(2);
  endtask

  task automatic press_clear();
    repeat (2) tick('0, 1'b1, 1'b1, 1'b0, door_lvl);
    idle(2);
  endtask

  task automatic clr_counts();
    n_load = 0;
    n_clear = 0;
    n_count = 0;
  endtask

  // Asynchronous reset mid-cycle; outputs must drop without a clock edge.
  task automatic reset_dut(input int cycles);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_state", bus.state_o, 2'd0);
    check("rst_entry", bus.entry_bcd, 12'h000);
    check("rst_load", bus.load_timer, 1'b0);
    check("rst_clear", bus.clear_timer, 1'b0);
    check("rst_count", bus.count_en, 1'b0);
    check("rst_mag", bus.mag_on, 1'b0);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    bus.kbd = '0;
    bus.startn = 1'b1;
    bus.stopn = 1'b1;
    bus.clearn = 1'b1;
    bus.door_closed = door_lvl;
    secs = 0;
    bus.timer_zero = 1'b1;
    pend_load = 1'b0;
    pend_clear = 1'b0;
    pend_count = 1'b0;
    pend_entry = '0;
    for (int i = 0; i < 3; i++) begin
      h_kbd[i] = '0;
      h_start[i] = 1'b1;
      h_stop[i] = 1'b1;
      h_clear[i] = 1'b1;
      h_door[i] = 1'b0;
    end
    h_door[0] = door_lvl;
    m_state = 0;
    m_elapsed = 0;
    clear_digits();
    exp_state = 2'd0;
    exp_entry = '0;
    exp_load = 1'b0;
    exp_clear = 1'b0;
    exp_count = 1'b0;
    exp_mag = 1'b0;
  endtask

  initial begin
    logic [9:0] rk;
    logic rs, rp, rc;
    int unsigned r;
    rst = 1'b1;
    door_lvl = 1'b1;
    bus.kbd = '0;
    bus.startn = 1'b1;
    bus.stopn = 1'b1;
    bus.clearn = 1'b1;
    bus.door_closed = 1'b1;
    bus.timer_zero = 1'b1;
    exp_load = 1'b0;
    reset_dut(3);
    idle(3);

    // Enter 0:12, cook to zero.
    key(1);
    key(2);
    idle(2);
    check("s1_entry", bus.entry_bcd, 12'h012);
    clr_counts();
    press_start();
    idle(4);
    check("s1_load_once", n_load, 1);
    check("s1_cook", bus.state_o, 2'd1);
    check("s1_mag", bus.mag_on, 1'b1);
    clr_counts();
    idle(1250);
    check("s1_ticks", n_count, 12);
    check("s1_idle", bus.state_o, 2'd0);
    check("s1_mag_off", bus.mag_on, 1'b0);
    check("s1_entry_zero", bus.entry_bcd, 12'h000);
    clr_counts();
    idle(300);
    check("s1_no_tick", n_count, 0);

    // 0:35, stop after ~5 s, then clear.
    key(3);
    key(5);
    press_start();
    idle(510);
    press_stop();
    check("s2_pause", bus.state_o, 2'd2);
    check("s2_mag_off", bus.mag_on, 1'b0);
    clr_counts();
    idle(300);
    check("s2_no_tick", n_count, 0);
    check("s2_still_pause", bus.state_o, 2'd2);
    press_clear();
    check("s2_clear_pulse", n_clear, 1);
    check("s2_idle", bus.state_o, 2'd0);
    check("s2_entry_zero", bus.entry_bcd, 12'h000);

    // 1:29, door opens mid-cook, resume without reload.
    key(1);
    key(2);
    key(9);
    idle(2);
    check("s3_entry", bus.entry_bcd, 12'h129);
    press_start();
    idle(50);
    door_lvl = 1'b0;
    idle(4);
    check("s3_pause", bus.state_o, 2'd2);
    check("s3_mag_off", bus.mag_on, 1'b0);
    door_lvl = 1'b1;
    idle(3);
    clr_counts();
    press_start();
    check("s3_resume", bus.state_o, 2'd1);
    check("s3_no_reload", n_load, 0);
    check("s3_mag_on", bus.mag_on, 1'b1);
    idle(20);

    // Reset mid-cook.
    reset_dut(2);
    idle(3);

    // Two keys at once, then start with empty entry.
    key(4);
    repeat (2) tick(10'b0000000110, 1'b1, 1'b1, 1'b1, door_lvl);
    idle(3);
    check("s5_multi_key", bus.entry_bcd, 12'h004);
    press_clear();
    clr_counts();
    press_start();
    idle(3);
    check("s5_empty_start", bus.state_o, 2'd0);
    check("s5_no_load", n_load, 0);
    key(8);
    key(0);
    clr_counts();
    press_start();
    idle(3);
    check("s5_entry_080", bus.entry_bcd, 12'h080);
    check("s5_load", n_load, 1);
    check("s5_cook", bus.state_o, 2'd1);
    idle(10);

    // Random panel activity against the model.
    rk = '0;
    for (int n = 0; n < 5000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5) rk = 10'(1 << $urandom_range(0, 9));
      else if (r < 7) rk = 10'($urandom);
      else if (r < 40) rk = '0;
      rs = ($urandom_range(0, 39) != 0);
      rp = ($urandom_range(0, 299) != 0);
      rc = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 249) == 0) door_lvl = ~door_lvl;
      tick(rk, rs, rp, rc, door_lvl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
